sad_cs_resolve_acc: RTL
=======================

Name: sad_cs_resolve_acc

Overview:
- Consumer end of the carry-save datapath. Upstream absolute-difference/4:2 compressor trees emit redundant (sum, carry) pairs; this block consumes them.
- Accumulates one SAD block of such pairs in carry-save form, one 4:2 vector compression per accepted beat.
- Resolves the redundant accumulator to a binary SAD with a multi-cycle segmented adder.
- Presents the result on a valid/ready output for the motion-search comparator.

Parameters:
- W, 12, width of each incoming sum/carry vector. Value of a beat = in_sum + in_carry; both are already aligned.
- ACC_W, 20, accumulator/result width. Must be a multiple of SEG_W and >= W.
- BLK_LEN, 16, maximum beats per block.
- SEG_W, 5, bits resolved per cycle in the final adder. NSEG = ACC_W/SEG_W.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_sum  in  W  redundant sum vector
- in_carry  in  W  redundant carry vector, same weight as in_sum
- in_last  in  1  qualifies an accepted beat as the final beat of the block
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sad  out  ACC_W  resolved SAD, modulo 2^ACC_W
- out_count  out  clog2(BLK_LEN+1)  number of beats in the block

Behaviour:
- Reset (rst high at a clk edge):
  - state=ACCUM; acc_s, acc_c, beat count, segment index and segment carry cleared to 0.
  - out_valid=0, out_sad=0, out_count=0.
  - in_ready is 0 while rst is high and 1 in the first cycle after rst deasserts.
- Reset wins over every other event, in any state, including mid-RESOLVE or mid-OUTPUT. Partial results are discarded and never presented.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - RESOLVE: in_ready=0, out_valid=0.
  - OUTPUT: in_ready=0, out_valid=1.
- Accept rule: a beat is accepted when in_valid && in_ready.
  - in_sum and in_carry are zero-extended to ACC_W.
  - The bit-serial 4:2 compressor row combines acc_s, acc_c, in_sum and in_carry.
  - Cell i: inputs (acc_s[i], acc_c[i], in_sum[i], in_carry[i]); cin is cout of cell i-1; cell 0 cin=0.
  - New acc_s = row sum. New acc_c = row carry shifted left by 1.
  - Bits beyond ACC_W are discarded, so all arithmetic is modulo 2^ACC_W.
  - The beat count increments on each accept.
- ACCUM->RESOLVE: taken on an accept where in_last=1 or the count reaches BLK_LEN. out_count latches the final count.
  - in_last on the BLK_LEN-th beat is redundant; the block still ends there.
  - A block always has >= 1 beat. in_valid without an accept is ignored.
- RESOLVE: one segment per cycle, segment index 0..NSEG-1, LSB segment first.
  - Segment k of out_sad = acc_s[k] + acc_c[k] + seg_carry; seg_carry is registered.
  - The carry out of the top segment is dropped.
  - out_sad bits are written in place. Unwritten upper segments hold stale contents, but out_valid=0 throughout RESOLVE.
  - After segment NSEG-1, go to OUTPUT.
- Latency: if the last beat is accepted at edge t, out_valid rises at edge t+NSEG+1 (NSEG=4: five edges).
- OUTPUT: out_sad and out_count are held stable until out_valid && out_ready.
  - On that edge: acc_s, acc_c and the count are cleared, and state goes to ACCUM.
  - in_ready is 1 the next cycle. There is no back-to-back overlap of blocks.
- in_sum, in_carry and in_last are don't-care when no beat is accepted.

Decomposition:
- Shared package sad_pkg:
  - state enum (ACCUM, RESOLVE, OUTPUT)
  - NSEG derivation
  - count-width function
  - elaboration check that ACC_W % SEG_W == 0
- Sub-module sad_cs_compress_row:
  - Combinational row of ACC_W 4:2 cells with the cout->cin chain.
  - Outputs sum and carry vectors; the parent applies the shift.
  - All state stays in sad_cs_resolve_acc.

Test Plan:
- Reset: rst high 2 cycles -> in_ready=0, out_valid=0, out_sad=0 during reset; in_ready=1 first cycle after.
- Full block (defaults): 16 beats of in_sum=5, in_carry=3, out_ready=1 -> out_valid rises 5 edges after last accept; out_sad=128, out_count=16; in_ready=1 next cycle.
- Early last: beats (100,0), (0,200), (4095,4095) with in_last on beat 3 -> out_sad=8490, out_count=3.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid, out_sad and out_count stable, in_ready=0 throughout, offered beats not accepted. Raise out_ready -> next cycle in_ready=1, and the next block result excludes old data.
- Wrap: ACC_W=15, 16 beats of (4095,4095) -> out_sad=32736 (131040 mod 32768).
- Reset mid-RESOLVE: assert rst at the 2nd RESOLVE cycle -> out_valid never rises; the following 1-beat block (7,0) with in_last -> out_sad=7, out_count=1.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared types and elaboration helpers for the carry-save SAD accumulate/resolve block.
// Holds the controller state encoding, default geometry and width-derivation functions.
package sad_pkg;

   typedef enum logic [1:0] {
      ST_ACCUM   = 2'd0,
      ST_RESOLVE = 2'd1,
      ST_OUTPUT  = 2'd2
   } state_t;

   localparam int W_DEF       = 12;
   localparam int ACC_W_DEF   = 20;
   localparam int BLK_LEN_DEF = 16;
   localparam int SEG_W_DEF   = 5;

   function automatic int nseg(input int acc_w, input int seg_w);
      return acc_w / seg_w;
   endfunction

   function automatic int cnt_width(input int blk_len);
      return $clog2(blk_len + 1);
   endfunction

   // The resolver walks whole segments only, and the accumulator must hold a full beat.
   function automatic bit cfg_ok(input int w, input int acc_w, input int seg_w);
      return (seg_w > 0) && (acc_w % seg_w == 0) && (acc_w >= w);
   endfunction

endpackage

// File: rtl/sad_cs_compress_row.sv
// Combinational row of N 4:2 compressor cells; each cell's cout feeds the next cell's cin.
// The parent is responsible for shifting carry_o left by one before storing it.
module sad_cs_compress_row
   import sad_pkg::*;
#(
   parameter int N = ACC_W_DEF
)
(
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic [N-1:0] c_i,
   input  logic [N-1:0] d_i,
   output logic [N-1:0] sum_o,
   output logic [N-1:0] carry_o
);

   // Two cascaded full adders per cell; the inter-cell cout is independent of cin, so no ripple.
   always_comb begin : row
      logic cin_v;
      logic s1_v;
      cin_v   = 1'b0;
      s1_v    = 1'b0;
      sum_o   = '0;
      carry_o = '0;
      for (int i = 0; i < N; i++) begin
         s1_v       = a_i[i] ^ b_i[i] ^ c_i[i];
         sum_o[i]   = s1_v ^ d_i[i] ^ cin_v;
         carry_o[i] = (s1_v & d_i[i]) | (s1_v & cin_v) | (d_i[i] & cin_v);
         cin_v      = (a_i[i] & b_i[i]) | (a_i[i] & c_i[i]) | (b_i[i] & c_i[i]);
      end
   end

endmodule

// File: rtl/sad_cs_resolve_acc.sv
// Accumulates a block of carry-save beats, resolves the redundant sum with a segmented
// adder (one segment per cycle, LSB first) and presents the SAD on a valid/ready port.
module sad_cs_resolve_acc
   import sad_pkg::*;
#(
   parameter int W       = W_DEF,
   parameter int ACC_W   = ACC_W_DEF,
   parameter int BLK_LEN = BLK_LEN_DEF,
   parameter int SEG_W   = SEG_W_DEF
)
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [W-1:0]                  in_sum,
   input  logic [W-1:0]                  in_carry,
   input  logic                          in_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [ACC_W-1:0]              out_sad,
   output logic [cnt_width(BLK_LEN)-1:0] out_count
);

   localparam int NSEG = nseg(ACC_W, SEG_W);
   localparam int CW   = cnt_width(BLK_LEN);
   localparam int IW   = $clog2(NSEG + 1);

   if (!cfg_ok(W, ACC_W, SEG_W)) begin : g_cfg_check
      $error("sad_cs_resolve_acc: ACC_W must be a multiple of SEG_W and at least W");
   end

   state_t            state_q, state_d;
   logic [ACC_W-1:0]  acc_s_q, acc_s_d;
   logic [ACC_W-1:0]  acc_c_q, acc_c_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     seg_idx_q, seg_idx_d;
   logic              seg_carry_q, seg_carry_d;
   logic [ACC_W-1:0]  out_sad_q, out_sad_d;
   logic [CW-1:0]     out_count_q, out_count_d;
   logic              out_valid_q, out_valid_d;
   logic              ready_q, ready_d;

   logic [ACC_W-1:0]  row_sum_s;
   logic [ACC_W-1:0]  row_carry_s;
   logic              accept_s;
   logic [CW-1:0]     cnt_inc_s;
   logic [SEG_W-1:0]  seg_a_s;
   logic [SEG_W-1:0]  seg_b_s;
   logic [SEG_W:0]    seg_sum_s;

   sad_cs_compress_row #(
      .N (ACC_W)
   ) u_row (
      .a_i     (acc_s_q),
      .b_i     (acc_c_q),
      .c_i     (ACC_W'(in_sum)),
      .d_i     (ACC_W'(in_carry)),
      .sum_o   (row_sum_s),
      .carry_o (row_carry_s)
   );

   assign in_ready  = ready_q & ~rst;
   assign out_valid = out_valid_q;
   assign out_sad   = out_sad_q;
   assign out_count = out_count_q;

   assign accept_s  = in_valid & in_ready;
   assign cnt_inc_s = cnt_q + CW'(1);
   assign seg_a_s   = SEG_W'(acc_s_q >> (int'(seg_idx_q) * SEG_W));
   assign seg_b_s   = SEG_W'(acc_c_q >> (int'(seg_idx_q) * SEG_W));
   assign seg_sum_s = {1'b0, seg_a_s} + {1'b0, seg_b_s} + (SEG_W+1)'(seg_carry_q);

   // Next-state logic for the accumulate / resolve / output sequence.
   always_comb begin
      state_d     = state_q;
      acc_s_d     = acc_s_q;
      acc_c_d     = acc_c_q;
      cnt_d       = cnt_q;
      seg_idx_d   = seg_idx_q;
      seg_carry_d = seg_carry_q;
      out_sad_d   = out_sad_q;
      out_count_d = out_count_q;
      out_valid_d = out_valid_q;
      ready_d     = ready_q;
      case (state_q)
         ST_ACCUM: begin
            if (accept_s) begin
               acc_s_d = row_sum_s;
               acc_c_d = row_carry_s << 1;
               cnt_d   = cnt_inc_s;
               if (in_last || (cnt_inc_s == CW'(BLK_LEN))) begin
                  state_d     = ST_RESOLVE;
                  out_count_d = cnt_inc_s;
                  seg_idx_d   = '0;
                  seg_carry_d = 1'b0;
                  ready_d     = 1'b0;
               end else begin
                  state_d = ST_ACCUM;
               end
            end else begin
               state_d = ST_ACCUM;
            end
         end
         ST_RESOLVE: begin
            // One extra cycle after the top segment lets out_valid rise NSEG+1 edges after the last beat.
            if (seg_idx_q == IW'(NSEG)) begin
               state_d     = ST_OUTPUT;
               out_valid_d = 1'b1;
            end else begin
               for (int k = 0; k < NSEG; k++) begin
                  if (int'(seg_idx_q) == k) begin
                     out_sad_d[k*SEG_W +: SEG_W] = seg_sum_s[SEG_W-1:0];
                  end else begin
                     out_sad_d[k*SEG_W +: SEG_W] = out_sad_q[k*SEG_W +: SEG_W];
                  end
               end
               seg_carry_d = seg_sum_s[SEG_W];
               seg_idx_d   = seg_idx_q + IW'(1);
            end
         end
         ST_OUTPUT: begin
            if (out_ready) begin
               state_d     = ST_ACCUM;
               acc_s_d     = '0;
               acc_c_d     = '0;
               cnt_d       = '0;
               out_valid_d = 1'b0;
               ready_d     = 1'b1;
            end else begin
               state_d = ST_OUTPUT;
            end
         end
         default: begin
            state_d     = ST_ACCUM;
            acc_s_d     = '0;
            acc_c_d     = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            ready_d     = 1'b1;
         end
      endcase
   end

   // State registers; reset discards any partial block.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ACCUM;
         acc_s_q     <= '0;
         acc_c_q     <= '0;
         cnt_q       <= '0;
         seg_idx_q   <= '0;
         seg_carry_q <= 1'b0;
         out_sad_q   <= '0;
         out_count_q <= '0;
         out_valid_q <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         acc_s_q     <= acc_s_d;
         acc_c_q     <= acc_c_d;
         cnt_q       <= cnt_d;
         seg_idx_q   <= seg_idx_d;
         seg_carry_q <= seg_carry_d;
         out_sad_q   <= out_sad_d;
         out_count_q <= out_count_d;
         out_valid_q <= out_valid_d;
         ready_q     <= ready_d;
      end
   end

endmodule
